// File: rtl/reg_store_cam.sv
// -----------------------------------------------------------------------------
// reg_store_cam
// Fully associative {id, data} register store with up to DEPTH entries.
// Stores overwrite on id hit (per-byte enables) or allocate the lowest free
// slot on a miss. Deletes invalidate an entry. Reads are pipelined with a
// latency of one cycle and return data plus a hit flag.
//
// Ports:
//   sys_clk       clock, rising edge
//   sys_rst       asynchronous active-low reset
//   store_data_f  store strobe
//   store_data    {id, data}, id in the MSBs
//   store_be      per-byte write enables for the store
//   del_f/del_id  delete strobe and id to invalidate
//   req_id_f/req_id   read request strobe and id
//   req_data      read data (holds until the next response)
//   req_data_f    read response strobe, one cycle after the request
//   req_hit       id was present (qualified by req_data_f)
//   store_ack     store accepted (pulse)
//   store_err     store rejected (pulse)
//   count         number of valid entries
//   full          count == DEPTH
// -----------------------------------------------------------------------------
module reg_store_cam #(
   parameter int ID_W   = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   store_data_f,
   input  logic [ID_W+DATA_W-1:0] store_data,
   input  logic [DATA_W/8-1:0]    store_be,
   input  logic                   del_f,
   input  logic [ID_W-1:0]        del_id,
   input  logic                   req_id_f,
   input  logic [ID_W-1:0]        req_id,
   output logic [DATA_W-1:0]      req_data,
   output logic                   req_data_f,
   output logic                   req_hit,
   output logic                   store_ack,
   output logic                   store_err,
   output logic [CNT_W-1:0]       count,
   output logic                   full
);

   localparam int BE_W = DATA_W / 8;

   // Entry storage: tags and data are only meaningful while valid, so they
   // carry no reset.
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ID_W-1:0]   tag_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [DATA_W-1:0] req_data_q, req_data_d;
   logic              req_data_f_q, req_hit_q, req_hit_d;
   logic              store_ack_q, store_err_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;

   logic [ID_W-1:0]   st_id;
   logic [DATA_W-1:0] st_wdata;
   logic [DATA_W-1:0] st_old_data, st_merged, rd_arr_data;
   logic [DEPTH-1:0]  st_hit_vec, del_hit_vec, rd_hit_vec;
   logic [DEPTH-1:0]  free_vec, alloc_vec, st_wr_vec;
   logic              st_hit, st_conflict, st_write, st_alloc, del_hit;

   assign st_id    = store_data[ID_W+DATA_W-1:DATA_W];
   assign st_wdata = store_data[DATA_W-1:0];

   // Parallel tag compare against every valid entry for all three ports.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
         assign st_hit_vec[gi]  = valid_q[gi] && (tag_q[gi] == st_id);
         assign del_hit_vec[gi] = del_f && valid_q[gi] && (tag_q[gi] == del_id);
         assign rd_hit_vec[gi]  = valid_q[gi] && (tag_q[gi] == req_id);
      end
   endgenerate

   // At most one entry matches a given id, so OR-reduction acts as a mux.
   always_comb begin
      st_old_data = '0;
      rd_arr_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (st_hit_vec[i]) st_old_data = st_old_data | data_q[i];
         if (rd_hit_vec[i]) rd_arr_data = rd_arr_data | data_q[i];
      end
   end

   // On a miss st_old_data is zero, so disabled bytes of a new entry are 0.
   generate
      for (gi = 0; gi < BE_W; gi++) begin : g_merge
         assign st_merged[8*gi +: 8] = store_be[gi] ? st_wdata[8*gi +: 8]
                                                    : st_old_data[8*gi +: 8];
      end
   endgenerate

   // Lowest-index free slot as a one-hot (isolate lowest set bit).
   assign free_vec  = ~valid_q;
   assign alloc_vec = free_vec & (~free_vec + DEPTH'(1));

   assign st_hit      = |st_hit_vec;
   assign del_hit     = |del_hit_vec;
   // Delete of the same id wins over the store.
   assign st_conflict = store_data_f && del_f && (del_id == st_id);
   // full_q is start-of-cycle state: a slot freed this cycle is not reusable yet.
   assign st_write    = store_data_f && !st_conflict && (st_hit || !full_q);
   assign st_alloc    = st_write && !st_hit;
   assign st_wr_vec   = st_write ? (st_hit ? st_hit_vec : alloc_vec) : '0;

   // A conflicting store never writes, so delete and write never target
   // the same entry.
   assign valid_d = (valid_q | st_wr_vec) & ~del_hit_vec;
   assign count_d = count_q + CNT_W'(st_alloc) - CNT_W'(del_hit);
   assign full_d  = (count_d == CNT_W'(DEPTH));

   // Read result with write-first bypass; a same-cycle delete forces a miss.
   always_comb begin
      req_hit_d  = 1'b0;
      req_data_d = '0;
      if (del_f && (del_id == req_id)) begin
         req_hit_d  = 1'b0;
         req_data_d = '0;
      end else if (st_write && (st_id == req_id)) begin
         req_hit_d  = 1'b1;
         req_data_d = st_merged;
      end else if (|rd_hit_vec) begin
         req_hit_d  = 1'b1;
         req_data_d = rd_arr_data;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         valid_q      <= '0;
         req_data_q   <= '0;
         req_data_f_q <= 1'b0;
         req_hit_q    <= 1'b0;
         store_ack_q  <= 1'b0;
         store_err_q  <= 1'b0;
         count_q      <= '0;
         full_q       <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         req_data_f_q <= req_id_f;
         if (req_id_f) begin
            req_data_q <= req_data_d;
            req_hit_q  <= req_hit_d;
         end
         store_ack_q  <= st_write;
         store_err_q  <= store_data_f && !st_write;
         count_q      <= count_d;
         full_q       <= full_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (st_wr_vec[i]) begin
            tag_q[i]  <= st_id;
            data_q[i] <= st_merged;
         end
      end
   end

   assign req_data   = req_data_q;
   assign req_data_f = req_data_f_q;
   assign req_hit    = req_hit_q;
   assign store_ack  = store_ack_q;
   assign store_err  = store_err_q;
   assign count      = count_q;
   assign full       = full_q;

endmodule

// File: tb/tb_reg_store_cam.sv
// -----------------------------------------------------------------------------
// tb_reg_store_cam
// Directed scenarios followed by randomized traffic. The reference model is an
// associative array keyed by id; a compare process checks every output on
// every falling edge against the model's expectations.
// -----------------------------------------------------------------------------
module tb_reg_store_cam;

   localparam int ID_W   = 8;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 5;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b0;
   logic              store_data_f = 1'b0;
   logic [39:0]       store_data = '0;
   logic [3:0]        store_be = '0;
   logic              del_f = 1'b0;
   logic [7:0]        del_id = '0;
   logic              req_id_f = 1'b0;
   logic [7:0]        req_id = '0;
   logic [31:0]       req_data;
   logic              req_data_f, req_hit, store_ack, store_err, full;
   logic [CNT_W-1:0]  count;

   reg_store_cam #(.ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .store_data_f(store_data_f), .store_data(store_data), .store_be(store_be),
      .del_f(del_f), .del_id(del_id),
      .req_id_f(req_id_f), .req_id(req_id),
      .req_data(req_data), .req_data_f(req_data_f), .req_hit(req_hit),
      .store_ack(store_ack), .store_err(store_err),
      .count(count), .full(full)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: id -> data for every present entry.
   logic [31:0] m_mem [int];

   logic [31:0] exp_data  = '0;
   logic        exp_f     = 1'b0;
   logic        exp_hit   = 1'b0;
   logic        exp_ack   = 1'b0;
   logic        exp_err   = 1'b0;
   int          exp_count = 0;
   logic        exp_full  = 1'b0;
   logic        cmp_en    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      if (cmp_en) begin
         check("req_data_f", 32'(req_data_f), 32'(exp_f));
         if (exp_f) check("req_hit", 32'(req_hit), 32'(exp_hit));
         check("req_data", req_data, exp_data);
         check("store_ack", 32'(store_ack), 32'(exp_ack));
         check("store_err", 32'(store_err), 32'(exp_err));
         check("count", 32'(count), 32'(exp_count));
         check("full", 32'(full), 32'(exp_full));
      end
   end

   // One clock cycle of stimulus; the model is evaluated on start-of-cycle state.
   task automatic cycle(input bit sf, input logic [7:0] sid, input logic [31:0] sdat,
                        input logic [3:0] sbe, input bit df, input logic [7:0] did,
                        input bit rf, input logic [7:0] rid);
      logic [31:0] old, merged, n_data;
      bit n_ack, n_err, n_hit, conflict;
      store_data_f = sf; store_data = {sid, sdat}; store_be = sbe;
      del_f = df; del_id = did; req_id_f = rf; req_id = rid;

      n_ack = 0; n_err = 0; n_hit = 0; merged = '0; n_data = exp_data;
      conflict = sf && df && (sid == did);
      if (sf) begin
         if (!conflict && (m_mem.exists(int'(sid)) || m_mem.num() < DEPTH)) begin
            old = m_mem.exists(int'(sid)) ? m_mem[int'(sid)] : 32'h0;
            for (int b = 0; b < 4; b++)
               merged[8*b +: 8] = sbe[b] ? sdat[8*b +: 8] : old[8*b +: 8];
            n_ack = 1;
         end else begin
            n_err = 1;
         end
      end
      if (rf) begin
         if (df && did == rid) begin
            n_hit = 0; n_data = '0;
         end else if (n_ack && sid == rid) begin
            n_hit = 1; n_data = merged;
         end else if (m_mem.exists(int'(rid))) begin
            n_hit = 1; n_data = m_mem[int'(rid)];
         end else begin
            n_hit = 0; n_data = '0;
         end
      end

      @(posedge sys_clk);
      #1;
      if (n_ack) m_mem[int'(sid)] = merged;
      if (df && m_mem.exists(int'(did))) m_mem.delete(int'(did));
      exp_ack   = n_ack;
      exp_err   = n_err;
      exp_f     = rf;
      if (rf) exp_hit = n_hit;
      exp_data  = n_data;
      exp_count = m_mem.num();
      exp_full  = (m_mem.num() == DEPTH);
   endtask

   task automatic idle();
      cycle(0, 8'h0, 32'h0, 4'h0, 0, 8'h0, 0, 8'h0);
   endtask

   task automatic store(input logic [7:0] id, input logic [31:0] d, input logic [3:0] be);
      cycle(1, id, d, be, 0, 8'h0, 0, 8'h0);
   endtask

   task automatic read(input logic [7:0] id);
      cycle(0, 8'h0, 32'h0, 4'h0, 0, 8'h0, 1, id);
   endtask

   task automatic del(input logic [7:0] id);
      cycle(0, 8'h0, 32'h0, 4'h0, 1, id, 0, 8'h0);
   endtask

   initial begin
      #1 cmp_en = 1'b1;
      #11 sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      check("rst_count", 32'(count), 32'd0);
      check("rst_req_data_f", 32'(req_data_f), 32'd0);

      // 1: store then read
      store(8'h01, 32'hFFFF_1111, 4'hF);
      check("t1_ack", 32'(store_ack), 32'd1);
      read(8'h01);
      check("t1_hit", 32'(req_hit), 32'd1);
      check("t1_data", req_data, 32'hFFFF_1111);
      check("t1_count", 32'(count), 32'd1);

      // 2: partial overwrite, miss read
      store(8'h01, 32'hAABB_CCDD, 4'b0101);
      read(8'h01);
      check("t2_data", req_data, 32'hFFBB_11DD);
      read(8'h02);
      check("t2_miss_hit", 32'(req_hit), 32'd0);
      check("t2_miss_data", req_data, 32'd0);

      // 3: fill, overflow, delete+store same cycle, then store into freed slot
      for (int i = 0; i < 16; i++) store(8'(i), 32'h1000_0000 + 32'(i), 4'hF);
      check("t3_full", 32'(full), 32'd1);
      check("t3_count", 32'(count), 32'd16);
      store(8'h20, 32'hDEAD_BEEF, 4'hF);
      check("t3_err", 32'(store_err), 32'd1);
      cycle(1, 8'h20, 32'hDEAD_BEEF, 4'hF, 1, 8'h05, 0, 8'h0);
      check("t3_err_same_cycle", 32'(store_err), 32'd1);
      check("t3_count15", 32'(count), 32'd15);
      store(8'h20, 32'hDEAD_BEEF, 4'hF);
      check("t3_ack", 32'(store_ack), 32'd1);
      read(8'h20);
      check("t3_read20", req_data, 32'hDEAD_BEEF);

      // 4: empty table, store+read bypass, store+delete conflict
      for (int i = 0; i < 16; i++) del(8'(i));
      del(8'h20);
      check("t4_empty", 32'(count), 32'd0);
      cycle(1, 8'h33, 32'h1234_5678, 4'hF, 0, 8'h0, 1, 8'h33);
      check("t4_bypass_hit", 32'(req_hit), 32'd1);
      check("t4_bypass_data", req_data, 32'h1234_5678);
      cycle(1, 8'h33, 32'h0BAD_0BAD, 4'hF, 1, 8'h33, 0, 8'h0);
      check("t4_conflict_err", 32'(store_err), 32'd1);
      read(8'h33);
      check("t4_after_del", 32'(req_hit), 32'd0);

      // 5: back-to-back reads alternating hit/miss
      store(8'h44, 32'h4444_0000, 4'hF);
      store(8'h55, 32'h5555_0000, 4'hF);
      for (int i = 0; i < 5; i++) begin
         read((i % 2 == 0) ? ((i == 2) ? 8'h55 : 8'h44) : 8'h99);
         check("t5_strobe", 32'(req_data_f), 32'd1);
      end

      // random traffic
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 99) < 60, 8'($urandom_range(0, 23)), $urandom,
               4'($urandom), $urandom_range(0, 99) < 25, 8'($urandom_range(0, 23)),
               $urandom_range(0, 99) < 60, 8'($urandom_range(0, 23)));
      end
      for (int i = 0; i < 24; i++) cycle(0, 8'h0, 32'h0, 4'h0, 0, 8'h0, 1, 8'(i));

      // 6: reset between a request and its response
      store(8'h01, 32'h0101_0101, 4'hF);
      store_data_f = 1'b0; req_id_f = 1'b1; req_id = 8'h01;
      #2 sys_rst = 1'b0;
      m_mem.delete();
      exp_f = 1'b0; exp_hit = 1'b0; exp_data = '0; exp_ack = 1'b0; exp_err = 1'b0;
      exp_count = 0; exp_full = 1'b0;
      #1;
      check("t6_data_now", req_data, 32'd0);
      check("t6_count_now", 32'(count), 32'd0);
      check("t6_strobe_now", 32'(req_data_f), 32'd0);
      req_id_f = 1'b0;
      @(posedge sys_clk); #1;
      check("t6_strobe_in_rst", 32'(req_data_f), 32'd0);
      @(negedge sys_clk); #1 sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      check("t6_strobe_after", 32'(req_data_f), 32'd0);
      idle();
      read(8'h01);
      check("t6_entry_gone", 32'(req_hit), 32'd0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
